// File: rtl/layer_train_driver_pkg.sv
// Shared types for layer_train_driver: [0,1] fixed-point values, FSM states and the error-width helper.
package layer_train_driver_pkg;

  localparam int FRAC_W = 8;

  typedef logic [FRAC_W-1:0] frac_t;
  // One integer bit on top of the fraction so that 1.0 is exactly representable.
  typedef logic [$bits(frac_t):0] zero2one_t;

  localparam zero2one_t Z2O_MAX = zero2one_t'(1 << FRAC_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_LEARN,
    ST_ERR,
    ST_DONE
  } state_t;

  function automatic int err_w(input int m);
    return $bits(zero2one_t) + $clog2(m);
  endfunction

endpackage

// File: rtl/layer_train_driver_if.sv
// Bus between layer_train_driver (master), its sample source and the layer it drives (slave side).
interface layer_train_driver_if
  import layer_train_driver_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 15
);
  localparam int ERR_W = err_w(M);

  logic             s_valid;
  logic             s_ready;
  zero2one_t        s_in         [N];
  zero2one_t        s_target     [M];
  logic             s_train;
  logic             valid;
  logic             learn;
  zero2one_t        in           [N];
  zero2one_t        expected_out [M];
  zero2one_t        out          [M];
  logic [ERR_W-1:0] err_sum;
  logic             done;
  logic [15:0]      sample_cnt;

  modport master (
    input  s_valid, s_in, s_target, s_train, out,
    output s_ready, valid, learn, in, expected_out, err_sum, done, sample_cnt
  );

  modport slave (
    output s_valid, s_in, s_target, s_train, out,
    input  s_ready, valid, learn, in, expected_out, err_sum, done, sample_cnt
  );

endinterface

// File: rtl/layer_train_driver_abs_err_accum.sv
// Running sum of |a-b|: synchronous clear wins over enable; one pair accumulated per enabled cycle.
module abs_err_accum
  import layer_train_driver_pkg::*;
#(
  parameter int SUM_W = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  zero2one_t        a,
  input  zero2one_t        b,
  output logic [SUM_W-1:0] sum
);

  zero2one_t        diff;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;

  always_comb begin
    diff  = (a >= b) ? (a - b) : (b - a);
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + SUM_W'(diff);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/layer_train_driver.sv
// Sequences one sample through a layer: settle, optional learn pulse, error scan, done.
// Define TRAIN_ERR_EN to build the per-sample |target-out| error path and ERR state.
module layer_train_driver
  import layer_train_driver_pkg::*;
#(
  parameter int N      = 16,
  parameter int M      = 15,
  parameter int SETTLE = 2
) (
  input logic                 clock,
  input logic                 reset,
  layer_train_driver_if.master bus
);

  localparam int ERR_W = err_w(M);
  localparam int IDX_W = $clog2(M);
  // Counter serves both the settle window (up to 15) and the output scan (up to M-1).
  localparam int CNT_W = (IDX_W > 4) ? IDX_W : 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST   = CNT_W'(M - 1);

`ifdef TRAIN_ERR_EN
  localparam state_t AFTER_LEARN = ST_ERR;
`else
  localparam state_t AFTER_LEARN = ST_DONE;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             capture;
  logic             train_q;
  logic             done_q;
  logic [15:0]      sample_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    bus.s_ready = 1'b0;
    bus.valid   = 1'b0;
    bus.learn   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.s_ready = 1'b1;
        cnt_d       = '0;
        if (bus.s_valid) begin
          capture = 1'b1;
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        bus.valid = 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = train_q ? ST_LEARN : AFTER_LEARN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LEARN: begin
        bus.valid = 1'b1;
        bus.learn = 1'b1;
        cnt_d     = '0;
        state_d   = AFTER_LEARN;
      end
      ST_ERR: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Layer-facing vectors come only from these capture registers.
  for (genvar gi = 0; gi < N; gi++) begin : g_in
    zero2one_t in_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        in_q <= '0;
      end else if (capture) begin
        in_q <= bus.s_in[gi];
      end
    end
    assign bus.in[gi] = in_q;
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_tgt
    zero2one_t tgt_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        tgt_q <= '0;
      end else if (capture) begin
        tgt_q <= bus.s_target[gi];
      end
    end
    assign bus.expected_out[gi] = tgt_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      train_q <= 1'b0;
    end else if (capture) begin
      train_q <= bus.s_train;
    end
  end

`ifdef TRAIN_ERR_EN
  logic [ERR_W-1:0] acc_sum;
  logic [ERR_W-1:0] err_sum_q;

  // Accumulator is held at zero outside ERR, so every scan starts from a clean sum.
  abs_err_accum #(
    .SUM_W (ERR_W)
  ) u_accum (
    .clock (clock),
    .reset (reset),
    .clear (state_q != ST_ERR),
    .en    (state_q == ST_ERR),
    .a     (bus.expected_out[cnt_q[IDX_W-1:0]]),
    .b     (bus.out[cnt_q[IDX_W-1:0]]),
    .sum   (acc_sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_sum_q <= '0;
    end else if (state_q == ST_DONE) begin
      err_sum_q <= acc_sum;
    end
  end

  assign bus.err_sum = err_sum_q;
`else
  assign bus.err_sum = '0;
`endif

  // done is registered, so it rises on the edge that leaves DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q       <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        sample_cnt_q <= sample_cnt_q + 16'd1;
      end
    end
  end

  assign bus.done       = done_q;
  assign bus.sample_cnt = sample_cnt_q;

endmodule

// File: doc/layer_train_driver.md
LAYER_TRAIN_DRIVER -- requirements
Module: layer_train_driver

Interface
REQ-001 SHALL have parameter N, default 16: number of layer inputs per sample.
REQ-002 SHALL have parameter M, default 15: number of layer outputs/neurons driven.
REQ-003 SHALL have parameter SETTLE, default 2, legal range 1..15: forward-settle cycles before learn.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port s_valid, input, 1 bit: a sample is offered.
REQ-007 SHALL have port s_ready, output, 1 bit: driver can accept a sample.
REQ-008 SHALL have port s_in, input, zero2one_t [N]: sample input vector.
REQ-009 SHALL have port s_target, input, zero2one_t [M]: sample target vector.
REQ-010 SHALL have port s_train, input, 1 bit: 1 = train on the sample, 0 = inference only.
REQ-011 SHALL have port valid, output, 1 bit: to layer valid.
REQ-012 SHALL have port learn, output, 1 bit: to layer learn.
REQ-013 SHALL have port in, output, zero2one_t [N]: to layer in.
REQ-014 SHALL have port expected_out, output, zero2one_t [M]: to layer expected_out.
REQ-015 SHALL have port out, input, zero2one_t [M]: from layer outputs.
REQ-016 SHALL have port err_sum, output, ERR_W bits: sum of |target-out| over the last sample.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse when a sample completes.
REQ-018 SHALL have port sample_cnt, output, 16 bits: count of completed samples.

Function
REQ-019 SHALL implement FSM IDLE -> FWD -> LEARN -> ERR -> DONE -> IDLE.
REQ-020 IDLE SHALL assert s_ready; on s_valid&&s_ready it SHALL capture s_in, s_target and s_train into registers, then enter FWD.
REQ-021 in and expected_out SHALL come only from the capture registers and stay stable from capture until the next capture.
REQ-022 FWD SHALL assert valid for exactly SETTLE cycles, then enter LEARN if the captured s_train=1, else ERR.
REQ-023 LEARN SHALL assert valid and learn together for exactly one cycle, then enter ERR.
REQ-024 ERR SHALL sample out[k] for k=0..M-1, one per cycle (M cycles).
REQ-025 ERR SHALL accumulate unsigned |s_target[k]-out[k]| into an ERR_W-bit accumulator, where ERR_W = width(zero2one_t)+clog2(M).
REQ-026 The accumulator SHALL clear on entry to ERR and SHALL never overflow.
REQ-027 DONE SHALL load err_sum, pulse done for 1 cycle, increment sample_cnt, then return to IDLE.
REQ-028 sample_cnt SHALL wrap from 0xFFFF to 0.
REQ-029 valid and learn SHALL be 0 in IDLE, ERR and DONE.
REQ-030 learn SHALL never assert without valid.
REQ-031 Sample latency SHALL be fixed: SETTLE+train+M+1 cycles from the capture edge to the done pulse.
REQ-032 s_ready SHALL be 0 outside IDLE; s_valid offered outside IDLE SHALL be ignored, not lost-captured.
REQ-033 s_valid held in IDLE SHALL start the next sample, giving back-to-back throughput of one sample per latency+1 cycles.

Reset
REQ-034 While reset=1, state SHALL be IDLE and s_ready SHALL be 1.
REQ-035 While reset=1, valid, learn and done SHALL be 0.
REQ-036 While reset=1, in, expected_out, err_sum and sample_cnt SHALL be 0.
REQ-037 Reset asserted mid-sample SHALL abort it immediately: no done pulse and no count increment.

Configuration
REQ-038 Macro TRAIN_ERR_EN SHALL select whether the error path is built.
REQ-039 With TRAIN_ERR_EN defined, the ERR state and err_sum SHALL behave as above.
REQ-040 Without TRAIN_ERR_EN, the ERR state SHALL be skipped (LEARN/FWD go directly to DONE), latency SHALL be SETTLE+train+1, and err_sum SHALL be tied to 0.

Structure
REQ-041 zero2one_t, frac_t and a clog2-based ERR_W helper SHALL live in the shared defs package; no local redefinition.
REQ-042 The absolute-difference accumulator SHALL be a sub-module abs_err_accum (clear, en, a, b, sum).

Verification
REQ-043 Reset mid-FWD: assert reset -> valid=0, s_ready=1, no done pulse, sample_cnt unchanged.
REQ-044 Train sample, SETTLE=2, M=15, layer out tied equal to target -> valid high 3 cycles, learn high exactly 1 cycle (the 3rd), done 19 cycles after capture, err_sum=0.
REQ-045 Inference sample (s_train=0), out[k]=0, target[k]=max for all k -> learn never asserts, err_sum=15*max, done 18 cycles after capture.
REQ-046 s_valid held high for 3 samples -> exactly 3 captures, s_ready low between them, sample_cnt=3, in stable during each FWD.
REQ-047 Preload sample_cnt to 0xFFFF by 65535 samples (or force), run one more -> sample_cnt=0.
REQ-048 Build without TRAIN_ERR_EN, train sample with SETTLE=2 -> done 4 cycles after capture, err_sum=0.
